// File: rtl/latency_encoding_mul_pipe.sv
// Pipelined signed x unsigned multiplier with optional rounded rescaling,
// output saturation and a sticky saturation event counter.
module latency_encoding_mul_pipe #(
  parameter int A_W       = 23,
  parameter int B_W       = 22,
  parameter int OUT_W     = 45,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 1,
  parameter int NUM_STAGE = 2,
  parameter int CNT_W     = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_W-1:0]          din0,
  input  logic [B_W-1:0]          din1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat,
  input  logic                    sat_clr,
  output logic [CNT_W-1:0]        sat_cnt
);

  localparam int unsigned PW  = A_W + B_W;
  localparam int unsigned RW  = PW + 1;
  // Product-carrying stages ahead of the final stage (at least one slot so
  // the array stays legal when NUM_STAGE=1; it is bypassed in that case).
  localparam int unsigned NP  = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RW-1:0] RND = (SHIFT > 0 && ROUND != 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    ce;
  logic [PW-1:0]           prod;
  logic [PW-1:0]           p_q [NP];
  logic [PW-1:0]           p_d [NP];
  logic [NP-1:0]           v_q, v_d;
  logic [PW-1:0]           fin_src;
  logic                    fin_v;
  logic [RW-1:0]           rnd_sum;
  logic signed [RW-1:0]    shifted;
  logic                    fits;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic                    sat_q, sat_d;
  logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;

  // Global advance: the whole pipe moves unless a valid output is blocked.
  always_comb begin
    ce       = ~out_valid_q | out_ready;
    in_ready = ce;
  end

  // Exact product: din0 sign-extended, din1 zero-extended to full width.
  always_comb begin
    prod = {{B_W{din0[A_W-1]}}, din0} * {{A_W{1'b0}}, din1};
  end

  // Intermediate stages carry the raw product and a valid bit; bubbles kept.
  always_comb begin
    p_d = p_q;
    v_d = v_q;
    if (ce) begin
      p_d[0] = prod;
      v_d[0] = in_valid;
      for (int unsigned i = 1; i < NP; i++) begin
        p_d[i] = p_q[i-1];
        v_d[i] = v_q[i-1];
      end
    end
  end

  // Final stage: round, arithmetic shift in one extra bit, then clip.
  always_comb begin
    fin_src     = (NUM_STAGE == 1) ? prod : p_q[NP-1];
    fin_v       = (NUM_STAGE == 1) ? in_valid : v_q[NP-1];
    rnd_sum     = {fin_src[PW-1], fin_src} + RND;
    shifted     = $signed(rnd_sum) >>> SHIFT;
    fits        = (shifted[RW-1:OUT_W-1] == '0) || (&shifted[RW-1:OUT_W-1]);
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    if (ce) begin
      out_valid_d = fin_v;
      if (fits) begin
        dout_d = shifted[OUT_W-1:0];
        sat_d  = 1'b0;
      end else begin
        dout_d = shifted[RW-1] ? MINV : MAXV;
        sat_d  = fin_v;
      end
    end
  end

  // Saturation event counter: clear has priority, holds at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && out_ready && sat_q && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset discarding in-flight samples.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      p_q         <= '{default: '0};
      v_q         <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      p_q         <= p_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    out_valid = out_valid_q;
    dout      = dout_q;
    sat       = sat_q;
    sat_cnt   = sat_cnt_q;
  end

endmodule

// File: tb/tb_latency_encoding_mul_pipe.sv
// Directed bench: four configurations share one stimulus stream.
//   u0 defaults (full width, latency 2)
//   u1 OUT_W=16 SHIFT=4 round, latency 1
//   u2 OUT_W=16 SHIFT=4 truncate, latency 4
//   u3 OUT_W=16 SHIFT=0, latency 3, 2-bit counter
module tb_latency_encoding_mul_pipe;

  typedef struct {
    logic [22:0]        a;
    logic [21:0]        b;
    logic signed [44:0] e0;
    logic signed [15:0] e1;
    logic               s1;
    logic signed [15:0] e2;
    logic               s2;
    logic signed [15:0] e3;
    logic               s3;
  } vec_t;

  logic clk, rst, in_valid, out_ready, sat_clr;
  logic [22:0] din0;
  logic [21:0] din1;

  logic ir0, ir1, ir2, ir3;
  logic ov0, ov1, ov2, ov3;
  logic sat0, sat1, sat2, sat3;
  logic signed [44:0] dout0;
  logic signed [15:0] dout1, dout2, dout3;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  int n_cmp = 0;
  int n_err = 0;
  longint ec[4];
  longint cmax[4] = '{65535, 65535, 65535, 3};
  vec_t vecs[15];
  vec_t vclip, vpost;

  latency_encoding_mul_pipe u0 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .din0(din0), .din1(din1), .out_valid(ov0), .out_ready(out_ready),
    .dout(dout0), .sat(sat0), .sat_clr(sat_clr), .sat_cnt(cnt0));

  latency_encoding_mul_pipe #(.OUT_W(16), .SHIFT(4), .ROUND(1), .NUM_STAGE(1)) u1 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .din0(din0), .din1(din1), .out_valid(ov1), .out_ready(out_ready),
    .dout(dout1), .sat(sat1), .sat_clr(sat_clr), .sat_cnt(cnt1));

  latency_encoding_mul_pipe #(.OUT_W(16), .SHIFT(4), .ROUND(0), .NUM_STAGE(4)) u2 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .din0(din0), .din1(din1), .out_valid(ov2), .out_ready(out_ready),
    .dout(dout2), .sat(sat2), .sat_clr(sat_clr), .sat_cnt(cnt2));

  latency_encoding_mul_pipe #(.OUT_W(16), .SHIFT(0), .NUM_STAGE(3), .CNT_W(2)) u3 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir3),
    .din0(din0), .din1(din1), .out_valid(ov3), .out_ready(out_ready),
    .dout(dout3), .sat(sat3), .sat_clr(sat_clr), .sat_cnt(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input longint a, input longint b, input longint e0,
                               input longint e1, input bit s1, input longint e2,
                               input bit s2, input longint e3, input bit s3);
    vec_t v;
    v.a  = a[22:0];
    v.b  = b[21:0];
    v.e0 = e0[44:0];
    v.e1 = e1[15:0];
    v.s1 = s1;
    v.e2 = e2[15:0];
    v.s2 = s2;
    v.e3 = e3[15:0];
    v.s3 = s3;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Apply one sample, watch every DUT for a bounded window, check value,
  // latency, single delivery and the saturation counters.
  task automatic run_vec(input string tag, input vec_t v, input bit clr);
    int     nv[4]  = '{0, 0, 0, 0};
    int     lat[4] = '{0, 0, 0, 0};
    longint dq[4]  = '{0, 0, 0, 0};
    bit     sq[4]  = '{0, 0, 0, 0};
    longint ee[4];
    bit     es[4];
    int     el[4]  = '{2, 1, 4, 3};
    ee = '{v.e0, v.e1, v.e2, v.e3};
    es = '{1'b0, v.s1, v.s2, v.s3};
    @(negedge clk);
    din0 = v.a;
    din1 = v.b;
    in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sat_clr  = 1'b0;
      if (ov0) begin nv[0]++; lat[0] = k; dq[0] = dout0; sq[0] = sat0; end
      if (ov1) begin nv[1]++; lat[1] = k; dq[1] = dout1; sq[1] = sat1; end
      if (ov2) begin nv[2]++; lat[2] = k; dq[2] = dout2; sq[2] = sat2; end
      if (ov3) begin nv[3]++; lat[3] = k; dq[3] = dout3; sq[3] = sat3; end
      if (clr && ov3) sat_clr = 1'b1;
    end
    sat_clr = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s u%0d count", tag, j), nv[j], 1);
      chk($sformatf("%s u%0d latency", tag, j), lat[j], el[j]);
      chk($sformatf("%s u%0d dout", tag, j), dq[j], ee[j]);
      chk($sformatf("%s u%0d sat", tag, j), sq[j], es[j]);
    end
    if (clr) begin
      ec = '{0, 0, 0, 0};
      if (es[2]) ec[2] = 1;
    end else begin
      for (int j = 0; j < 4; j++)
        if (es[j]) ec[j] = (ec[j] + 1 > cmax[j]) ? cmax[j] : ec[j] + 1;
    end
    chk($sformatf("%s u0 sat_cnt", tag), cnt0, ec[0]);
    chk($sformatf("%s u1 sat_cnt", tag), cnt1, ec[1]);
    chk($sformatf("%s u2 sat_cnt", tag), cnt2, ec[2]);
    chk($sformatf("%s u3 sat_cnt", tag), cnt3, ec[3]);
  endtask

  initial begin
    int     sent, got;
    bit     acc;
    longint held;

    vecs[0]  = mkv(-3, 5, -15, -1, 0, -1, 0, -15, 0);
    vecs[1]  = mkv(300, 200, 60000, 3750, 0, 3750, 0, 32767, 1);
    vecs[2]  = mkv(-300, 200, -60000, -3750, 0, -3750, 0, -32768, 1);
    vecs[3]  = mkv(-40, 1, -40, -2, 0, -3, 0, -40, 0);
    vecs[4]  = mkv(24, 1, 24, 2, 0, 1, 0, 24, 0);
    vecs[5]  = mkv(23, 1, 23, 1, 0, 1, 0, 23, 0);
    vecs[6]  = mkv(8, 1, 8, 1, 0, 0, 0, 8, 0);
    vecs[7]  = mkv(-8, 1, -8, 0, 0, -1, 0, -8, 0);
    vecs[8]  = mkv(-4194304, 4194303, -64'sd17592181850112, -32768, 1, -32768, 1, -32768, 1);
    vecs[9]  = mkv(4194303, 4194303, 64'sd17592177655809, 32767, 1, 32767, 1, 32767, 1);
    vecs[10] = mkv(0, 4194303, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mkv(32767, 1, 32767, 2048, 0, 2047, 0, 32767, 0);
    vecs[12] = mkv(-32768, 1, -32768, -2048, 0, -2048, 0, -32768, 0);
    vecs[13] = mkv(32768, 1, 32768, 2048, 0, 2048, 0, 32767, 1);
    vecs[14] = mkv(-32769, 1, -32769, -2048, 0, -2049, 0, -32768, 1);
    vclip    = vecs[1];
    vpost    = mkv(7, 2, 14, 1, 0, 0, 0, 14, 0);
    ec = '{0, 0, 0, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    din0 = '0; din1 = '0;
    #1;
    chk("reset ov", {ov0, ov1, ov2, ov3}, 0);
    chk("reset sat", {sat0, sat1, sat2, sat3}, 0);
    chk("reset dout0", dout0, 0);
    chk("reset cnt", {cnt0, cnt1, cnt2, cnt3}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec($sformatf("v%0d", i), vecs[i], 1'b0);

    // Clear coincides with a clipped delivery on u3: clear wins.
    run_vec("clr", vclip, 1'b1);
    run_vec("clip", vclip, 1'b0);

    // Asynchronous reset with two samples in flight.
    @(negedge clk);
    din0 = 23'd5; din1 = 22'd1; in_valid = 1'b1;
    @(negedge clk);
    din0 = 23'd6;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("async rst ov", {ov0, ov1, ov2, ov3}, 0);
    chk("async rst cnt3", cnt3, 0);
    chk("async rst dout0", dout0, 0);
    ec = '{0, 0, 0, 0};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post rst idle %0d", k), {ov0, ov1, ov2, ov3}, 0);
    end
    run_vec("post", vpost, 1'b0);

    // Backpressure on u0: 1..6 streamed, out_ready low for three cycles.
    @(negedge clk);
    sent = 1; got = 0; held = 0;
    din0 = 23'd1; din1 = 22'd1; in_valid = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      #1;
      if (!out_ready) begin
        chk($sformatf("bp in_ready c%0d", c), ir0, 0);
        chk($sformatf("bp ov c%0d", c), ov0, 1);
        if (c == 4) held = dout0;
        else chk($sformatf("bp hold c%0d", c), dout0, held);
      end
      if (ov0 && out_ready) begin
        got++;
        chk($sformatf("bp order %0d", got), dout0, got);
      end
      acc = in_valid && ir0;
      @(negedge clk);
      if (acc) begin
        sent++;
        if (sent <= 6) din0 = 23'(sent);
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    chk("bp total", got, 6);
    chk("bp held value", held, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/latency_encoding_mul_pipe.md
Name: latency_encoding_mul_pipe

Overview:
Parametrised, pipelined signed × unsigned multiplier for the latency-encoding datapath. It is the successor to the single-cycle combinational multiply. It adds:
- a configurable pipeline depth with valid/ready flow control,
- an optional rounded arithmetic right shift for fixed-point rescaling,
- output saturation with a per-sample flag and a sticky event counter.

It sits between the input-normalisation stage and the spike-time threshold comparator.

Parameters:
- A_W, 23, width of signed operand din0
- B_W, 22, width of unsigned operand din1
- OUT_W, 45, width of signed result dout; range 2..A_W+B_W
- SHIFT, 0, arithmetic right shift applied to the full product; range 0..A_W+B_W-2
- ROUND, 1, 1 = round half up (add 2^(SHIFT-1) before the shift); 0 = truncate; ignored when SHIFT=0
- NUM_STAGE, 2, pipeline latency in cycles; range 1..4
- CNT_W, 16, width of the saturation event counter

Ports:
- ap_clk, in, 1, clock; all state updates on the rising edge
- ap_rst, in, 1, asynchronous active-high reset
- in_valid, in, 1, din0/din1 valid
- in_ready, out, 1, block accepts input this cycle
- din0, in, A_W, signed multiplicand
- din1, in, B_W, unsigned multiplier (zero-extended)
- out_valid, out, 1, dout valid
- out_ready, in, 1, downstream accepts dout
- dout, out, OUT_W, scaled and saturated signed product
- sat, out, 1, dout for this sample was clipped; qualified by out_valid
- sat_clr, in, 1, synchronous clear of sat_cnt
- sat_cnt, out, CNT_W, number of clipped samples delivered; saturates at all-ones

Behaviour:
- Reset: ap_rst is asynchronous and active-high. While asserted, all stage valids, out_valid, dout, sat and sat_cnt are 0. Release takes effect on the next ap_clk edge.
- Arithmetic:
  - Full product P = signed(din0) × signed({1'b0, din1}), width A_W+B_W, always exact.
  - If SHIFT>0 and ROUND=1: R = (P + 2^(SHIFT-1)) >>> SHIFT, computed in A_W+B_W+1 bits so no intermediate overflow. Otherwise R = P >>> SHIFT.
  - Saturation: if R > 2^(OUT_W-1)-1, dout = 2^(OUT_W-1)-1 and sat=1. If R < -2^(OUT_W-1), dout = -2^(OUT_W-1) and sat=1. Else dout = R and sat=0.
- Pipeline:
  - NUM_STAGE register stages, each holding a valid bit plus data.
  - Multiply sits in stage 1; rounding, shift and saturation sit in the final stage. With NUM_STAGE=1, all of it is in one stage.
  - Global advance: ce = ~out_valid | out_ready. All stages shift when ce=1; the pipeline holds completely when ce=0.
  - in_ready = ce, combinational.
  - A sample is accepted when in_valid & in_ready. An accepted sample appears on dout exactly NUM_STAGE cycles later if there is no stall. Each stall cycle adds one cycle.
  - Bubbles (in_valid=0 at an accepting edge) propagate as valid=0 stages. They are not collapsed.
- Output hold: while out_valid & ~out_ready, dout, sat and out_valid stay stable. No sample is lost, duplicated or reordered.
- Throughput: one sample per cycle while out_ready=1.
- sat_cnt:
  - Increments by 1 on each cycle where out_valid & out_ready & sat.
  - Holds at 2^CNT_W-1; no wrap.
  - sat_clr=1 loads 0. Clear wins over a simultaneous increment.
- Reset mid-operation: in-flight samples are discarded. No partial output is produced after reset release.

Test Plan:
- Defaults, out_ready=1: din0=-3, din1=5 accepted at cycle t → out_valid=1 at t+2 with dout=-15, sat=0.
- Defaults, extreme operands: din0=-2^22, din1=2^22-1 → dout = -2^44+2^22 exactly, sat=0; sat_cnt stays 0.
- OUT_W=16, SHIFT=4, ROUND=1, din1=1:
  - din0=-40 → -2
  - din0=24 → 2
  - din0=23 → 1
  - with ROUND=0, din0=23 → 1 and din0=-40 → -3
- OUT_W=16, SHIFT=0:
  - 300×200 → dout=32767, sat=1, sat_cnt=1
  - -300×200 → dout=-32768, sat=1, sat_cnt=2
  - sat_clr pulsed in the same cycle as a third clipped sample is delivered → sat_cnt=0
- Backpressure: stream inputs 1..6 (din1=1) back-to-back, drop out_ready for 3 cycles mid-stream → in_ready low during the stall, outputs exactly 1..6 in order, dout stable while stalled.
- Reset: assert ap_rst asynchronously (between edges) with 2 samples in flight → out_valid and sat_cnt go to 0 immediately; after release, a new sample 7×2 yields dout=14 after NUM_STAGE cycles with no stale outputs.
